// File: rtl/hazard_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_pkg
//   Shared definitions for the hazard / forwarding control block:
//   forwarding-source encodings, the stall FSM state type, the x0 register
//   index and the per-stage source-match helper used by fwd_select.
// -----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    // Operand-source encodings driven to the EX-stage operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Hard-wired zero register; it is never a forwarding or hazard source.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Stall-sequencing FSM states.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } hfu_state_e;

    // A pipeline stage supplies a source operand when it writes the register
    // file, targets that register, and the register is not x0.
    function automatic logic stage_match(input logic       rf_enable,
                                         input logic [4:0] rd,
                                         input logic [4:0] src);
        return rf_enable && (rd == src) && (rd != REG_X0);
    endfunction

endpackage : hazard_forward_unit_pkg

// File: rtl/hazard_forward_unit_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Purely combinational forwarding-source selector for one EX operand.
//   The youngest producer wins: EX over MEM over WB; no producer selects the
//   register file.
//
// Ports:
//   src_reg        in   5  source register of the ID-stage instruction
//   ex_rd          in   5  EX-stage destination register
//   ex_rf_enable   in   1  EX-stage instruction writes the register file
//   mem_rd         in   5  MEM-stage destination register
//   mem_rf_enable  in   1  MEM-stage instruction writes the register file
//   wb_rd          in   5  WB-stage destination register
//   wb_rf_enable   in   1  WB-stage instruction writes the register file
//   fwd_sel        out  2  selected source (FWD_RF/EX/MEM/WB)
// -----------------------------------------------------------------------------
module fwd_select
    import hazard_forward_unit_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic [4:0] ex_rd,
    input  logic       ex_rf_enable,
    input  logic [4:0] mem_rd,
    input  logic       mem_rf_enable,
    input  logic [4:0] wb_rd,
    input  logic       wb_rf_enable,
    output logic [1:0] fwd_sel
);

    logic ex_hit_s;
    logic mem_hit_s;
    logic wb_hit_s;

    assign ex_hit_s  = stage_match(ex_rf_enable,  ex_rd,  src_reg);
    assign mem_hit_s = stage_match(mem_rf_enable, mem_rd, src_reg);
    assign wb_hit_s  = stage_match(wb_rf_enable,  wb_rd,  src_reg);

    // Priority encoder: youngest matching stage supplies the operand.
    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_hit_s) begin
            fwd_sel = FWD_EX;
        end else if (mem_hit_s) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit_s) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule : fwd_select

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//   Control end of the IF/ID and ID/EX pipeline registers. Generates the PC and
//   IF/ID load enables, the IF/ID flush and the ID/EX bubble, selects operand
//   forwarding sources for EX, and sequences multi-cycle load-use stalls that a
//   taken control transfer in EX can abort.
//
//   Control outputs respond in the same cycle as the hazard / taken inputs;
//   only the stall state and stall counter are held in flops.
//
// Parameters:
//   LOAD_USE_STALLS  bubble cycles per load-use hazard (1..3)
//   CNT_W            width of the optional performance counters
//
// Ports:
//   clk, Reset                       clock, synchronous active-high reset
//   ID_RS1/ID_RS2, ID_Use_RS1/2      ID-stage sources and their use bits
//   EX_RD/EX_RF_Enable/EX_Load_Instr EX-stage producer information
//   MEM_RD/MEM_RF_Enable             MEM-stage producer information
//   WB_RD/WB_RF_Enable               WB-stage producer information
//   EX_Taken                         taken branch / JAL / JALR resolved in EX
//   PC_LE, IF_ID_LE                  load enables
//   IF_Flush, ID_EX_Bubble           IF/ID clear, ID/EX NOP insertion
//   Fwd_A_Sel, Fwd_B_Sel             operand sources (00 RF,01 EX,10 MEM,11 WB)
//   Stall_Active                     FSM is in STALL
//   Stall_Cycles, Flush_Count        saturating counters, only when
//                                    HAZARD_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_Use_RS1,
    input  logic             ID_Use_RS2,
    input  logic [4:0]       EX_RD,
    input  logic             EX_RF_Enable,
    input  logic             EX_Load_Instr,
    input  logic [4:0]       MEM_RD,
    input  logic             MEM_RF_Enable,
    input  logic [4:0]       WB_RD,
    input  logic             WB_RF_Enable,
    input  logic             EX_Taken,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_Flush,
    output logic             ID_EX_Bubble,
    output logic [1:0]       Fwd_A_Sel,
    output logic [1:0]       Fwd_B_Sel,
    output logic             Stall_Active
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Count
`endif
);

    // Remaining bubbles after the detection cycle (at most 2).
    localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALLS - 1);
    localparam bit         MULTI_STALL = (LOAD_USE_STALLS > 1);

    hfu_state_e state_r;
    logic [1:0] cnt_r;
    logic       hz_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // ---------------------------------------------------------------- forwarding
    fwd_select u_fwd_a (
        .src_reg       (ID_RS1),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_Enable),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_Enable),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_Enable),
        .fwd_sel       (fwd_a_s)
    );

    fwd_select u_fwd_b (
        .src_reg       (ID_RS2),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_Enable),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_Enable),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_Enable),
        .fwd_sel       (fwd_b_s)
    );

    // Forwarding selects are forced to the register file while in reset.
    always_comb begin
        Fwd_A_Sel = FWD_RF;
        Fwd_B_Sel = FWD_RF;
        if (Reset) begin
            Fwd_A_Sel = FWD_RF;
            Fwd_B_Sel = FWD_RF;
        end else begin
            Fwd_A_Sel = fwd_a_s;
            Fwd_B_Sel = fwd_b_s;
        end
    end

    // ------------------------------------------------------- load-use detection
    // Unlike forwarding, the hazard honours the use bits: a load result that the
    // ID instruction does not actually read needs no bubble.
    assign hz_s = EX_Load_Instr && EX_RF_Enable && (EX_RD != REG_X0) &&
                  ((ID_Use_RS1 && (ID_RS1 == EX_RD)) ||
                   (ID_Use_RS2 && (ID_RS2 == EX_RD)));

    // ---------------------------------------------------------------- stall FSM
    // State and bubble counter; a taken transfer always wins over a stall.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= RUN;
            cnt_r   <= 2'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (EX_Taken) begin
                        state_r <= RUN;
                        cnt_r   <= 2'd0;
                    end else if (hz_s && MULTI_STALL) begin
                        state_r <= STALL;
                        cnt_r   <= STALL_INIT;
                    end else begin
                        state_r <= RUN;
                        cnt_r   <= 2'd0;
                    end
                end
                STALL: begin
                    if (EX_Taken) begin
                        state_r <= RUN;
                        cnt_r   <= 2'd0;
                    end else if (cnt_r <= 2'd1) begin
                        // Counter reaches zero on this edge: last bubble done.
                        state_r <= RUN;
                        cnt_r   <= 2'd0;
                    end else begin
                        state_r <= STALL;
                        cnt_r   <= cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

    // Pipeline-register controls decoded from state, reset, taken and hazard.
    always_comb begin
        PC_LE        = 1'b1;
        IF_ID_LE     = 1'b1;
        IF_Flush     = 1'b0;
        ID_EX_Bubble = 1'b0;
        Stall_Active = 1'b0;
        if (Reset) begin
            PC_LE        = 1'b0;
            IF_ID_LE     = 1'b0;
            IF_Flush     = 1'b1;
            ID_EX_Bubble = 1'b1;
            Stall_Active = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    Stall_Active = 1'b0;
                    if (EX_Taken) begin
                        // Redirect: fetch the target, squash IF/ID and ID/EX.
                        PC_LE        = 1'b1;
                        IF_ID_LE     = 1'b1;
                        IF_Flush     = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if (hz_s) begin
                        PC_LE        = 1'b0;
                        IF_ID_LE     = 1'b0;
                        IF_Flush     = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end else begin
                        PC_LE        = 1'b1;
                        IF_ID_LE     = 1'b1;
                        IF_Flush     = 1'b0;
                        ID_EX_Bubble = 1'b0;
                    end
                end
                STALL: begin
                    Stall_Active = 1'b1;
                    if (EX_Taken) begin
                        PC_LE        = 1'b1;
                        IF_ID_LE     = 1'b1;
                        IF_Flush     = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else begin
                        PC_LE        = 1'b0;
                        IF_ID_LE     = 1'b0;
                        IF_Flush     = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end
                end
                default: begin
                    PC_LE        = 1'b0;
                    IF_ID_LE     = 1'b0;
                    IF_Flush     = 1'b1;
                    ID_EX_Bubble = 1'b1;
                    Stall_Active = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------ performance counters
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_count_r;

    // Saturating event counters for frozen-PC cycles and flush cycles.
    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (!PC_LE && (stall_cycles_r != CNT_MAX)) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (IF_Flush && (flush_count_r != CNT_MAX)) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign Stall_Cycles = stall_cycles_r;
    assign Flush_Count  = flush_count_r;
`endif

endmodule : hazard_forward_unit

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//   Drives two instances (LOAD_USE_STALLS = 1 and 3) with identical stimulus.
//   Each driven cycle pushes the expected outputs of both instances onto a
//   scoreboard queue; a negedge process pops and compares them.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset;
    logic [4:0] ID_RS1, ID_RS2, EX_RD, MEM_RD, WB_RD;
    logic       ID_Use_RS1, ID_Use_RS2, EX_RF_Enable, EX_Load_Instr;
    logic       MEM_RF_Enable, WB_RF_Enable, EX_Taken;

    logic       d1_pc, d1_ifid, d1_fl, d1_bb, d1_st;
    logic [1:0] d1_fa, d1_fb;
    logic       d3_pc, d3_ifid, d3_fl, d3_bb, d3_st;
    logic [1:0] d3_fa, d3_fb;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] d1_sc, d1_fc, d3_sc, d3_fc;
`endif

    hazard_forward_unit #(.LOAD_USE_STALLS(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .Reset(Reset),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_Use_RS1(ID_Use_RS1), .ID_Use_RS2(ID_Use_RS2),
        .EX_RD(EX_RD), .EX_RF_Enable(EX_RF_Enable), .EX_Load_Instr(EX_Load_Instr),
        .MEM_RD(MEM_RD), .MEM_RF_Enable(MEM_RF_Enable),
        .WB_RD(WB_RD), .WB_RF_Enable(WB_RF_Enable), .EX_Taken(EX_Taken),
        .PC_LE(d1_pc), .IF_ID_LE(d1_ifid), .IF_Flush(d1_fl), .ID_EX_Bubble(d1_bb),
        .Fwd_A_Sel(d1_fa), .Fwd_B_Sel(d1_fb), .Stall_Active(d1_st)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Cycles(d1_sc), .Flush_Count(d1_fc)
`endif
    );

    hazard_forward_unit #(.LOAD_USE_STALLS(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .Reset(Reset),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_Use_RS1(ID_Use_RS1), .ID_Use_RS2(ID_Use_RS2),
        .EX_RD(EX_RD), .EX_RF_Enable(EX_RF_Enable), .EX_Load_Instr(EX_Load_Instr),
        .MEM_RD(MEM_RD), .MEM_RF_Enable(MEM_RF_Enable),
        .WB_RD(WB_RD), .WB_RF_Enable(WB_RF_Enable), .EX_Taken(EX_Taken),
        .PC_LE(d3_pc), .IF_ID_LE(d3_ifid), .IF_Flush(d3_fl), .ID_EX_Bubble(d3_bb),
        .Fwd_A_Sel(d3_fa), .Fwd_B_Sel(d3_fb), .Stall_Active(d3_st)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Cycles(d3_sc), .Flush_Count(d3_fc)
`endif
    );

    // Control patterns {PC_LE, IF_ID_LE, IF_Flush, ID_EX_Bubble, Stall_Active}.
    localparam logic [4:0] C_RUN  = 5'b11000;
    localparam logic [4:0] C_HZ   = 5'b00010;
    localparam logic [4:0] C_STL  = 5'b00011;
    localparam logic [4:0] C_FLS  = 5'b11110;
    localparam logic [4:0] C_FLST = 5'b11111;
    localparam logic [4:0] C_RST  = 5'b00110;

    typedef struct {
        string      tag;
        logic [8:0] e1;
        logic [8:0] e3;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference forwarding: later assignments override, so EX beats MEM beats WB.
    function automatic logic [1:0] ref_sel(input logic [4:0] src);
        logic [1:0] s;
        s = 2'b00;
        if (src != 5'd0) begin
            if (WB_RF_Enable  && (WB_RD  == src)) s = 2'b11;
            if (MEM_RF_Enable && (MEM_RD == src)) s = 2'b10;
            if (EX_RF_Enable  && (EX_RD  == src)) s = 2'b01;
        end
        return s;
    endfunction

    task automatic push(input string tag, input logic [4:0] c1, input logic [4:0] c3);
        exp_t       e;
        logic [3:0] f;
        f     = Reset ? 4'b0000 : {ref_sel(ID_RS1), ref_sel(ID_RS2)};
        e.tag = tag;
        e.e1  = {c1, f};
        e.e3  = {c3, f};
        sb_q.push_back(e);
    endtask

    task automatic idle();
        Reset = 1'b0;
        ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_Use_RS1 = 1'b0; ID_Use_RS2 = 1'b0;
        EX_RD = 5'd0; EX_RF_Enable = 1'b0; EX_Load_Instr = 1'b0;
        MEM_RD = 5'd0; MEM_RF_Enable = 1'b0;
        WB_RD = 5'd0; WB_RF_Enable = 1'b0; EX_Taken = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_hz(input logic [4:0] rd, input bit via_rs1);
        EX_Load_Instr = 1'b1; EX_RF_Enable = 1'b1; EX_RD = rd;
        if (via_rs1) begin
            ID_RS1 = rd; ID_Use_RS1 = 1'b1;
        end else begin
            ID_RS2 = rd; ID_Use_RS2 = 1'b1;
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] s1, input logic [31:0] f1,
                           input logic [31:0] s3, input logic [31:0] f3);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_sc1"}, d1_sc, s1);
        chk({tag, "_fc1"}, d1_fc, f1);
        chk({tag, "_sc3"}, d3_sc, s3);
        chk({tag, "_fc3"}, d3_fc, f3);
`endif
    endtask

    // Scoreboard consumer: compare both instances mid-cycle.
    always @(negedge clk) begin : sb_check
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, "_d1"}, 32'({d1_pc, d1_ifid, d1_fl, d1_bb, d1_st, d1_fa, d1_fb}), 32'(e.e1));
            chk({e.tag, "_d3"}, 32'({d3_pc, d3_ifid, d3_fl, d3_bb, d3_st, d3_fa, d3_fb}), 32'(e.e3));
        end
    end

    initial begin
        idle();
        Reset = 1'b1;
        // Reset with live matches and a hazard: outputs must still be forced.
        cyc(); idle(); Reset = 1'b1; load_hz(5'd5, 1'b1); MEM_RD = 5'd5; MEM_RF_Enable = 1'b1;
        push("rst0", C_RST, C_RST);
        cyc(); Reset = 1'b1; EX_Taken = 1'b1;
        push("rst1", C_RST, C_RST);

        // Forwarding priority and x0 / use-bit boundaries.
        cyc(); idle(); EX_RD = 5'd5; EX_RF_Enable = 1'b1; MEM_RD = 5'd5; MEM_RF_Enable = 1'b1;
        ID_RS1 = 5'd5; ID_Use_RS1 = 1'b1;
        push("ex_over_mem", C_RUN, C_RUN);
        chk_cnt("cnt_after_rst", 32'd0, 32'd0, 32'd0, 32'd0);
        cyc(); idle(); EX_RD = 5'd0; EX_RF_Enable = 1'b1; ID_RS1 = 5'd0;
        WB_RD = 5'd7; WB_RF_Enable = 1'b1; ID_RS2 = 5'd7;
        push("x0_and_wb", C_RUN, C_RUN);
        cyc(); idle(); MEM_RD = 5'd9; MEM_RF_Enable = 1'b1; ID_RS1 = 5'd9;
        push("use_not_gating", C_RUN, C_RUN);
        cyc(); idle(); load_hz(5'd0, 1'b1);
        push("load_x0", C_RUN, C_RUN);
        cyc(); idle(); load_hz(5'd4, 1'b1); ID_Use_RS1 = 1'b0;
        push("load_unused", C_RUN, C_RUN);
        cyc(); idle(); load_hz(5'd4, 1'b0); EX_RF_Enable = 1'b0;
        push("load_no_wr", C_RUN, C_RUN);

        // Load-use hazard: 1 bubble vs 3 bubbles; hazard re-presented in STALL.
        cyc(); idle(); load_hz(5'd3, 1'b0);
        push("hz_a", C_HZ, C_HZ);
        cyc(); idle(); MEM_RD = 5'd3; MEM_RF_Enable = 1'b1; ID_RS2 = 5'd3; ID_Use_RS2 = 1'b1;
        push("hz_b", C_RUN, C_STL);
        cyc(); idle(); load_hz(5'd3, 1'b0);
        push("hz_c", C_HZ, C_STL);
        cyc(); idle();
        push("hz_d", C_RUN, C_RUN);
        chk_cnt("cnt_hz", 32'd2, 32'd0, 32'd3, 32'd0);

        // Taken with coincident hazard, then taken aborting a stall.
        cyc(); idle(); load_hz(5'd3, 1'b0); EX_Taken = 1'b1;
        push("tk_hz", C_FLS, C_FLS);
        cyc(); idle();
        push("tk_after", C_RUN, C_RUN);
        cyc(); idle(); load_hz(5'd6, 1'b1);
        push("ab_a", C_HZ, C_HZ);
        cyc(); idle(); EX_Taken = 1'b1;
        push("ab_b", C_FLS, C_FLST);
        cyc(); idle();
        push("ab_c", C_RUN, C_RUN);
        chk_cnt("cnt_tk", 32'd3, 32'd2, 32'd4, 32'd2);

        // Reset in the middle of a stall.
        cyc(); idle(); load_hz(5'd6, 1'b1);
        push("rs_a", C_HZ, C_HZ);
        cyc(); Reset = 1'b1;
        push("rs_b", C_RST, C_RST);
        cyc(); idle();
        push("rs_c", C_RUN, C_RUN);
        chk_cnt("cnt_rs", 32'd0, 32'd0, 32'd0, 32'd0);

        // Random forwarding patterns over a small register range to force overlaps.
        for (int i = 0; i < 40; i++) begin
            cyc(); idle();
            ID_RS1 = 5'($urandom_range(0, 3)); ID_RS2 = 5'($urandom_range(0, 3));
            ID_Use_RS1 = 1'($urandom_range(0, 1)); ID_Use_RS2 = 1'($urandom_range(0, 1));
            EX_RD = 5'($urandom_range(0, 3)); EX_RF_Enable = 1'($urandom_range(0, 1));
            MEM_RD = 5'($urandom_range(0, 3)); MEM_RF_Enable = 1'($urandom_range(0, 1));
            WB_RD = 5'($urandom_range(0, 3)); WB_RF_Enable = 1'($urandom_range(0, 1));
            push("rnd", C_RUN, C_RUN);
        end

        cyc(); idle();
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_hazard_forward_unit
